// File: rtl/ctr_pkg.sv
// Shared definitions for the bounded up/down counter.
//   MODE_*  : boundary behaviour selector values for the 2-bit mode input
//             (encoding 3 is reserved and treated as saturate)
//   dir_t   : counting direction, also the state of the bounce FSM
package ctr_pkg;

    localparam logic [1:0] MODE_SAT    = 2'd0;
    localparam logic [1:0] MODE_WRAP   = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_t;

    // Only wrap and bounce report a boundary crossing as an event;
    // saturation clips silently.
    function automatic logic mode_has_evt(input logic [1:0] m);
        return (m == MODE_WRAP) || (m == MODE_BOUNCE);
    endfunction

endpackage

// File: rtl/ctr_step_calc.sv
// Combinational next-value calculation for one counting step.
// Ports:
//   count, step, lo, hi : current value, increment and limits (unsigned)
//   mode                : MODE_SAT / MODE_WRAP / MODE_BOUNCE (3 acts as SAT)
//   dir                 : effective direction for this step
//   nxt                 : value after the step with the boundary rule applied
//   hit                 : the raw step would have left [lo,hi]
//   turn                : bounce mode reversed direction on this step
// Assumes count already lies inside [lo,hi]; the caller handles snapping.
module ctr_step_calc
    import ctr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [1:0]       mode,
    input  dir_t             dir,
    output logic [WIDTH-1:0] nxt,
    output logic             hit,
    output logic             turn
);

    // One extra bit catches carry out of the top and borrow below zero.
    logic [WIDTH:0] up_sum;
    logic [WIDTH:0] dn_diff;
    logic           over;
    logic           under;

    assign up_sum  = {1'b0, count} + {1'b0, step};
    assign dn_diff = {1'b0, count} - {1'b0, step};
    assign over    = up_sum > {1'b0, hi};
    assign under   = dn_diff[WIDTH] || (dn_diff[WIDTH-1:0] < lo);

    always_comb begin
        nxt  = count;
        hit  = 1'b0;
        turn = 1'b0;
        if (dir == DIR_UP) begin
            if (over) begin
                hit = 1'b1;
                case (mode)
                    MODE_WRAP:   nxt = lo;
                    MODE_BOUNCE: begin
                        nxt  = hi;
                        turn = 1'b1;
                    end
                    default:     nxt = hi;
                endcase
            end else begin
                nxt = up_sum[WIDTH-1:0];
            end
        end else begin
            if (under) begin
                hit = 1'b1;
                case (mode)
                    MODE_WRAP:   nxt = hi;
                    MODE_BOUNCE: begin
                        nxt  = lo;
                        turn = 1'b1;
                    end
                    default:     nxt = lo;
                endcase
            end else begin
                nxt = dn_diff[WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/updown_bounded_counter.sv
// Up/down counter with runtime limits [lo,hi], programmable step and
// saturate / wrap / bounce boundary handling, plus enable and clamped load.
// Ports:
//   clk, rst        : rising-edge clock, synchronous active-high reset
//   en, load, data  : enable; load (clamped to [lo,hi]) takes priority over counting
//   dir, mode       : direction (seeds bounce), boundary mode
//   lo, hi, step    : unsigned limits and increment
//   count           : registered count
//   cur_dir         : bounce state in BOUNCE mode, dir input otherwise
//   at_max, at_min  : count equals hi / lo (combinational)
//   evt             : one-cycle pulse after a wrap or bounce turn
//   cfg_err         : lo > hi (combinational); freezes the counter
module updown_bounded_counter
    import ctr_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] step,
    output logic [WIDTH-1:0] count,
    output logic             cur_dir,
    output logic             at_max,
    output logic             at_min,
    output logic             evt,
    output logic             cfg_err
);

    logic [WIDTH-1:0] count_q, count_d;
    dir_t             dir_q, dir_d;
    logic             evt_q, evt_d;

    dir_t             eff_dir;
    logic [WIDTH-1:0] step_nxt;
    logic             step_hit;
    logic             step_turn;

    function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] v,
                                               input logic [WIDTH-1:0] lo_v,
                                               input logic [WIDTH-1:0] hi_v);
        if (v < lo_v)
            return lo_v;
        else if (v > hi_v)
            return hi_v;
        else
            return v;
    endfunction

    assign cfg_err = lo > hi;
    assign eff_dir = (mode == MODE_BOUNCE) ? dir_q : dir_t'(dir);

    ctr_step_calc #(
        .WIDTH (WIDTH)
    ) u_step (
        .count (count_q),
        .step  (step),
        .lo    (lo),
        .hi    (hi),
        .mode  (mode),
        .dir   (eff_dir),
        .nxt   (step_nxt),
        .hit   (step_hit),
        .turn  (step_turn)
    );

    always_comb begin
        count_d = count_q;
        dir_d   = dir_q;
        evt_d   = 1'b0;
        if (cfg_err || !en) begin
            // frozen: hold count and direction
        end else if (load) begin
            count_d = clamp(data, lo, hi);
            dir_d   = dir_t'(dir);
        end else if (count_q < lo || count_q > hi) begin
            // Limits moved under the count (or reset value outside them):
            // pull back inside first, no step this cycle.
            count_d = clamp(count_q, lo, hi);
        end else begin
            count_d = step_nxt;
            evt_d   = step_hit && mode_has_evt(mode);
            if (mode == MODE_BOUNCE)
                dir_d = step_turn ? ((dir_q == DIR_UP) ? DIR_DOWN : DIR_UP) : dir_q;
            else
                dir_d = dir_t'(dir);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= RST_VAL;
            dir_q   <= DIR_UP;
            evt_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            dir_q   <= dir_d;
            evt_q   <= evt_d;
        end
    end

    assign count   = count_q;
    assign evt     = evt_q;
    assign cur_dir = eff_dir;
    assign at_max  = count_q == hi;
    assign at_min  = count_q == lo;

endmodule
